// File: rtl/scratch_fifo.sv
// Bus-mapped 256-bit scratch FIFO with DATA/STATUS/CLEAR registers at address[15:12]==BASE.
// Optional sticky overflow/underflow flags are enabled by defining SCRATCH_FIFO_FLAGS_EN.
module scratch_fifo #(
  parameter int         DEPTH = 8,
  parameter logic [3:0] BASE  = 4'h5
) (
  input  logic         Clk,
  input  logic         Reset,
  output logic [255:0] DataOut,
  input  logic [255:0] DataIn,
  input  logic [15:0]  address,
  input  logic         nRead,
  input  logic         nWrite
);

  localparam int DATA_W = 256;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [11:0] OFF_DATA   = 12'h000;
  localparam logic [11:0] OFF_STATUS = 12'h001;
  localparam logic [11:0] OFF_CLEAR  = 12'h002;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rd_hist_q, wr_hist_q;

  logic              sel;
  logic [11:0]       off;
  logic              rd_low, wr_low;
  logic              proto_err;
  logic              rd_first, wr_first;
  logic              empty, full;
  logic              push, pop, clr;
  logic              ovf_flag, unf_flag;

  function automatic logic [DATA_W-1:0] status_word(
    input logic             unf,
    input logic             ovf,
    input logic             is_full,
    input logic             is_empty,
    input logic [CNT_W-1:0] cnt
  );
    logic [DATA_W-1:0] s;
    s       = '0;
    s[11]   = unf;
    s[10]   = ovf;
    s[9]    = is_full;
    s[8]    = is_empty;
    s[7:0]  = 8'(cnt);
    return s;
  endfunction

  assign sel    = (address[15:12] == BASE);
  assign off    = address[11:0];
  assign rd_low = ~nRead;
  assign wr_low = ~nWrite;

  // Both strobes low is a protocol error; neither strobe may act in that cycle.
  assign proto_err = sel & rd_low & wr_low;
  assign rd_first  = sel & rd_low & ~rd_hist_q & ~wr_low;
  assign wr_first  = sel & wr_low & ~wr_hist_q & ~rd_low;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  assign push = wr_first & (off == OFF_DATA) & ~full;
  assign pop  = rd_first & (off == OFF_DATA) & ~empty;
  assign clr  = wr_first & (off == OFF_CLEAR);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end
  end

  // DataOut only changes on a read action, a protocol error, or strobe release.
  always_comb begin
    dout_d = dout_q;
    if (nRead || proto_err) begin
      dout_d = '0;
    end else if (rd_first) begin
      case (off)
        OFF_DATA:   dout_d = pop ? mem_q[rd_ptr_q] : '0;
        OFF_STATUS: dout_d = status_word(unf_flag, ovf_flag, full, empty, count_q);
        default:    dout_d = '0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dout_q    <= '0;
      rd_hist_q <= 1'b0;
      wr_hist_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dout_q    <= dout_d;
      rd_hist_q <= rd_low;
      wr_hist_q <= wr_low;
    end
  end

  always_ff @(posedge Clk) begin
    if (push && !Reset) begin
      mem_q[wr_ptr_q] <= DataIn;
    end
  end

`ifdef SCRATCH_FIFO_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  logic push_drop, pop_empty;

  assign push_drop = wr_first & (off == OFF_DATA) & full;
  assign pop_empty = rd_first & (off == OFF_DATA) & empty;

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (push_drop) ovf_d = 1'b1;
      if (pop_empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf_flag = ovf_q;
  assign unf_flag = unf_q;
`else
  assign ovf_flag = 1'b0;
  assign unf_flag = 1'b0;
`endif

  assign DataOut = dout_q;

endmodule

// File: tb/tb_scratch_fifo.sv
// Directed scoreboard bench for scratch_fifo: a reference queue model predicts every read result.
module tb_scratch_fifo;

  localparam int DEPTH = 8;
`ifdef SCRATCH_FIFO_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  localparam logic [15:0] A_DATA   = 16'h5000;
  localparam logic [15:0] A_STATUS = 16'h5001;
  localparam logic [15:0] A_CLEAR  = 16'h5002;
  localparam logic [15:0] A_OTHER  = 16'h5123;
  localparam logic [15:0] A_UNSEL  = 16'h6000;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [255:0] DataOut;
  logic [255:0] DataIn;
  logic [15:0]  address;
  logic         nRead;
  logic         nWrite;

  int checks   = 0;
  int failures = 0;

  logic [255:0] mdl[$];
  logic [255:0] exp_q[$];
  bit           m_ovf, m_unf;

  scratch_fifo #(.DEPTH(DEPTH), .BASE(4'h5)) dut (
    .Clk(Clk), .Reset(Reset), .DataOut(DataOut), .DataIn(DataIn),
    .address(address), .nRead(nRead), .nWrite(nWrite)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] model_status();
    logic [255:0] s;
    s       = '0;
    s[11]   = m_unf & FLAGS;
    s[10]   = m_ovf & FLAGS;
    s[9]    = (mdl.size() == DEPTH);
    s[8]    = (mdl.size() == 0);
    s[7:0]  = 8'(mdl.size());
    return s;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic sb_check(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      chk(tag, DataOut, exp_q.pop_front());
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [255:0] d);
    address = a;
    DataIn  = d;
    nWrite  = 1'b0;
    @(posedge Clk); #1;
    nWrite  = 1'b1;
    if (a[15:12] == 4'h5) begin
      if (a[11:0] == 12'h000) begin
        if (mdl.size() < DEPTH) mdl.push_back(d);
        else m_ovf = 1'b1;
      end else if (a[11:0] == 12'h002) begin
        mdl.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
    end
    @(posedge Clk); #1;
  endtask

  task automatic do_read(input logic [15:0] a, input string tag);
    logic [255:0] e;
    e = '0;
    if (a[11:0] == 12'h000) begin
      if (mdl.size() > 0) e = mdl.pop_front();
      else m_unf = 1'b1;
    end else if (a[11:0] == 12'h001) begin
      e = model_status();
    end
    exp_q.push_back(e);
    address = a;
    nRead   = 1'b0;
    @(posedge Clk); #1;
    sb_check(tag);
    nRead   = 1'b1;
    @(posedge Clk); #1;
    chk({tag, "_release"}, DataOut, 256'h0);
  endtask

  initial begin
    Reset = 1'b1; nRead = 1'b1; nWrite = 1'b1; address = '0; DataIn = '0;
    m_ovf = 1'b0; m_unf = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_dataout", DataOut, 256'h0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    do_read(A_STATUS, "status_after_reset");
    chk("status_after_reset_model", model_status(), 256'h100);

    do_write(A_DATA, 256'hA);
    do_write(A_DATA, 256'hB);
    do_write(A_DATA, 256'hC);
    for (int i = 0; i < 3; i++) do_read(A_DATA, $sformatf("abc_pop%0d", i));
    do_read(A_STATUS, "abc_status");

    for (int i = 1; i <= 9; i++) do_write(A_DATA, 256'(i));
    do_read(A_STATUS, "full_status");
    chk("full_status_model", model_status(), FLAGS ? 256'h608 : 256'h208);
    for (int i = 0; i < 8; i++) do_read(A_DATA, $sformatf("full_pop%0d", i));
    do_write(A_CLEAR, 256'hFFFF);
    do_read(A_STATUS, "status_after_clear");

    address = A_DATA; DataIn = 256'h7; nWrite = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    nWrite = 1'b1;
    mdl.push_back(256'h7);
    @(posedge Clk); #1;
    do_read(A_STATUS, "held_write_status");
    do_read(A_DATA, "held_write_pop");

    do_write(A_CLEAR, '0);
    for (int i = 0; i < 3; i++) do_write(A_DATA, 256'h100 + 256'(i));
    for (int i = 0; i < 3; i++) do_read(A_DATA, $sformatf("pre_wrap_pop%0d", i));
    for (int i = 0; i < 7; i++) do_write(A_DATA, {8'hA5, 240'h0, 8'(i)});
    do_read(A_STATUS, "wrap_status");
    for (int i = 0; i < 7; i++) do_read(A_DATA, $sformatf("wrap_pop%0d", i));
    do_read(A_STATUS, "wrap_status_end");

    do_read(A_DATA, "empty_pop");
    do_read(A_STATUS, "underflow_status");
    do_write(A_CLEAR, '0);

    do_write(A_UNSEL, 256'h55);
    do_write(A_OTHER, 256'h66);
    do_write(A_STATUS, 256'h77);
    do_read(A_STATUS, "unselected_status");
    do_write(A_DATA, 256'hBEEF);
    do_read(A_OTHER, "other_offset_read");
    do_read(A_STATUS, "other_offset_status");

    address = A_DATA; DataIn = 256'hDEAD; nRead = 1'b0; nWrite = 1'b0;
    @(posedge Clk); #1;
    chk("proto_err_dataout", DataOut, 256'h0);
    nRead = 1'b1; nWrite = 1'b1;
    @(posedge Clk); #1;
    do_read(A_STATUS, "proto_err_status");
    do_read(A_DATA, "proto_err_pop");

    for (int i = 0; i < 4; i++) do_write(A_DATA, 256'h40 + 256'(i));
    do_read(A_STATUS, "pre_reset_status");
    address = A_DATA; nRead = 1'b0; Reset = 1'b1;
    @(posedge Clk); #1;
    chk("reset_mid_read0", DataOut, 256'h0);
    @(posedge Clk); #1;
    chk("reset_mid_read1", DataOut, 256'h0);
    Reset = 1'b0; nRead = 1'b1;
    mdl.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge Clk); #1;
    do_read(A_STATUS, "status_after_midreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scratch_fifo.md
SCRATCH_FIFO -- requirements
Module: scratch_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of 256-bit FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter BASE, default 4'h5, meaning the address[15:12] value that selects this block.
REQ-003 SHALL have port Clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port DataOut  output  256  read data returned to Execution.
REQ-006 SHALL have port DataIn  input  256  write data driven by Execution (ExeDataOut).
REQ-007 SHALL have port address  input  16  bus address; [15:12] selects the block, [11:0] is the offset.
REQ-008 SHALL have port nRead  input  1  active-low read strobe.
REQ-009 SHALL have port nWrite  input  1  active-low write strobe.

Function
REQ-010 SHALL act as a bus responder, selected only when address[15:12]==BASE; unselected cycles change no state.
REQ-011 SHALL decode offsets: 12'h000 DATA (write=push, read=pop), 12'h001 STATUS (read only), 12'h002 CLEAR (write only); other offsets: no state change, reads return zero.
REQ-012 SHALL act once per strobe assertion: a push/pop/clear occurs only in the first cycle a strobe is sampled low (previous-cycle strobe registered high); holding the strobe low for N cycles still performs one action.
REQ-013 SHALL, on a DATA push with count<DEPTH, write DataIn at the write pointer, advance it modulo DEPTH, increment count.
REQ-014 SHALL, on a DATA pop with count>0, register the head entry onto DataOut at that edge (visible the cycle after the strobe is first sampled), advance the read pointer modulo DEPTH, decrement count.
REQ-015 SHALL hold DataOut until the next read action; DataOut becomes zero at the edge after the read strobe is sampled high.
REQ-016 SHALL, on a STATUS read, register DataOut = {zeros, underflow[11], overflow[10], full[9], empty[8], count[7:0]}, same one-cycle latency.
REQ-017 SHALL drop a push when full (count, pointers, contents unchanged).
REQ-018 SHALL, on a pop when empty, return zero and leave pointers and count unchanged.
REQ-019 SHALL, on a CLEAR write, zero pointers, count and sticky flags; DataIn ignored; entry contents need not be cleared.
REQ-020 SHALL treat nRead and nWrite both low in the same cycle as a protocol error: no push/pop/clear, DataOut driven zero.
REQ-021 SHALL wrap pointers from DEPTH-1 to 0 with no loss of ordering; empty is count==0, full is count==DEPTH.

Reset
REQ-022 SHALL, while Reset is high at a rising edge, set pointers, count, flags, DataOut and registered strobe history to zero (history = strobes inactive), overriding any simultaneous bus action.
REQ-023 SHALL, after a reset mid-transaction, treat a strobe still held low as a new first-cycle assertion on the first edge after Reset deasserts.

Configuration
REQ-024 SHALL, with macro SCRATCH_FIFO_FLAGS_EN defined, set sticky overflow on a dropped push and sticky underflow on an empty pop; cleared only by CLEAR or Reset.
REQ-025 SHALL, without SCRATCH_FIFO_FLAGS_EN, implement no flag registers; STATUS bits [11:10] read zero; all other behaviour identical.

Verification
REQ-026 SHALL cover: after reset, STATUS read -> DataOut = 256'h100 (empty, count 0).
REQ-027 SHALL cover: push 256'hA, 256'hB, 256'hC, then pop 3 times -> DataOut sequence A, B, C, then STATUS = 256'h100.
REQ-028 SHALL cover: DEPTH=8, push 9 words 1..9 -> STATUS = 256'h608 with flags (256'h208 without); 8 pops return 1..8.
REQ-029 SHALL cover: nWrite held low 5 cycles on DATA with DataIn=256'h7 -> count becomes 1, not 5.
REQ-030 SHALL cover: 3 pushes, 3 pops, then 7 more pushes (pointer wrap) -> pops return the 7 words in order; STATUS reads 256'h100 after the last pop.
REQ-031 SHALL cover: Reset asserted with count=4 while nRead low on DATA -> next STATUS = 256'h100, DataOut zero during reset.
